// File: rtl/servo_capture.sv
// Four-channel RC servo pulse-width decoder: measures high time per channel,
// validates against width limits and tracks glitches, over-long pulses and signal loss.
module servo_capture #(
    parameter int unsigned MIN_WIDTH = 12000,
    parameter int unsigned MAX_WIDTH = 36000,
    parameter int unsigned TIMEOUT   = 480000
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    input  logic [3:0]  servo_in,
    input  logic        clear_status,
    output logic [15:0] pulse_width_0,
    output logic [15:0] pulse_width_1,
    output logic [15:0] pulse_width_2,
    output logic [15:0] pulse_width_3,
    output logic [3:0]  new_sample,
    output logic [3:0]  valid,
    output logic [3:0]  error,
    output logic [3:0]  lost
);

    localparam logic [15:0] MIN_W = 16'(MIN_WIDTH);
    localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);
    localparam logic [18:0] TMO   = 19'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t      state_q [4];
    state_t      state_d [4];
    logic [15:0] count_q [4];
    logic [15:0] count_d [4];
    logic [15:0] width_q [4];
    logic [15:0] width_d [4];
    logic [18:0] tmo_q   [4];
    logic [18:0] tmo_d   [4];

    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] rise;
    logic [3:0] new_d, valid_d, error_d, lost_d;

    assign rise = sync2_q & ~prev_q;

    assign pulse_width_0 = width_q[0];
    assign pulse_width_1 = width_q[1];
    assign pulse_width_2 = width_q[2];
    assign pulse_width_3 = width_q[3];

    always_comb begin
        new_d   = '0;
        valid_d = valid;
        error_d = error & {4{~clear_status}};
        lost_d  = lost;
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            width_d[i] = width_q[i];
            tmo_d[i]   = tmo_q[i];

            if (tmo_q[i] != TMO) begin
                tmo_d[i] = tmo_q[i] + 19'd1;
            end
            if (tmo_q[i] == TMO - 19'd1) begin
                lost_d[i]  = 1'b1;
                valid_d[i] = 1'b0;
                width_d[i] = '0;
            end

            // Accept is evaluated after expiry so it overrides a same-cycle timeout.
            unique case (state_q[i])
                ST_SYNC: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise[i]) begin
                        state_d[i] = ST_HIGH;
                        count_d[i] = 16'd1;
                    end
                end
                ST_HIGH: begin
                    if (sync2_q[i]) begin
                        if (count_q[i] == MAX_W) begin
                            error_d[i] = 1'b1;
                            state_d[i] = ST_SYNC;
                        end else begin
                            count_d[i] = count_q[i] + 16'd1;
                        end
                    end else if (count_q[i] >= MIN_W) begin
                        width_d[i] = count_q[i];
                        new_d[i]   = 1'b1;
                        valid_d[i] = 1'b1;
                        lost_d[i]  = 1'b0;
                        tmo_d[i]   = '0;
                        state_d[i] = ST_LOW;
                    end else begin
                        error_d[i] = 1'b1;
                        state_d[i] = ST_LOW;
                    end
                end
                default: begin
                    state_d[i] = ST_SYNC;
                end
            endcase
        end
    end

    // Synchroniser resets high so a pulse already high at reset release is skipped.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            prev_q     <= '1;
            new_sample <= '0;
            valid      <= '0;
            error      <= '0;
            lost       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= ST_SYNC;
                count_q[i] <= '0;
                width_q[i] <= '0;
                tmo_q[i]   <= '0;
            end
        end else begin
            sync1_q    <= servo_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            new_sample <= new_d;
            valid      <= valid_d;
            error      <= error_d;
            lost       <= lost_d;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                width_q[i] <= width_d[i];
                tmo_q[i]   <= tmo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_servo_capture.sv
// Scoreboard bench for servo_capture with limits scaled by 1/100 (120/360/4800 cycles).
module tb_servo_capture;

    logic        raw_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  servo_in;
    logic        clear_status;
    logic [15:0] pulse_width_0, pulse_width_1, pulse_width_2, pulse_width_3;
    logic [3:0]  new_sample, valid, error, lost;

    int passed = 0;
    int total  = 0;
    int exp_q [4][$];

    servo_capture #(
        .MIN_WIDTH(120),
        .MAX_WIDTH(360),
        .TIMEOUT  (4800)
    ) dut (
        .raw_clk      (raw_clk),
        .reset_n      (reset_n),
        .servo_in     (servo_in),
        .clear_status (clear_status),
        .pulse_width_0(pulse_width_0),
        .pulse_width_1(pulse_width_1),
        .pulse_width_2(pulse_width_2),
        .pulse_width_3(pulse_width_3),
        .new_sample   (new_sample),
        .valid        (valid),
        .error        (error),
        .lost         (lost)
    );

    always #5 raw_clk = ~raw_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] width_of(input int c);
        case (c)
            0:       return pulse_width_0;
            1:       return pulse_width_1;
            2:       return pulse_width_2;
            default: return pulse_width_3;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge raw_clk);
    endtask

    // Rising edges are staggered so that all falling edges land on the same clock.
    task automatic drive_vec(input int w0, input int w1, input int w2, input int w3);
        int w[4];
        int m;
        w = '{w0, w1, w2, w3};
        m = 0;
        for (int c = 0; c < 4; c++) if (w[c] > m) m = w[c];
        for (int t = 0; t < m; t++) begin
            @(negedge raw_clk);
            for (int c = 0; c < 4; c++) servo_in[c] = (t >= m - w[c]);
        end
        @(negedge raw_clk);
        servo_in = '0;
    endtask

    always @(negedge raw_clk) begin
        if (reset_n === 1'b1) begin
            for (int c = 0; c < 4; c++) begin
                if (new_sample[c]) begin
                    if (exp_q[c].size() == 0) begin
                        check($sformatf("unexpected_strobe_ch%0d", c), 64'(width_of(c)), 64'hdead);
                    end else begin
                        int e;
                        e = exp_q[c].pop_front();
                        check($sformatf("width_ch%0d", c), 64'(width_of(c)), 64'(e));
                        check($sformatf("valid_on_strobe_ch%0d", c), 64'(valid[c]), 64'd1);
                        check($sformatf("lost_on_strobe_ch%0d", c), 64'(lost[c]), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        servo_in     = '0;
        clear_status = 1'b0;
        idle(3);
        check("reset_widths", {pulse_width_0, pulse_width_1, pulse_width_2, pulse_width_3}, 64'd0);
        check("reset_new_sample", 64'(new_sample), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_lost", 64'(lost), 64'd0);
        reset_n = 1'b1;
        idle(5);

        // 1: nominal pulse on ch0
        exp_q[0].push_back(180);
        drive_vec(180, 0, 0, 0);
        idle(2400 - 181);
        check("t1_width0", 64'(pulse_width_0), 64'd180);
        check("t1_valid0", 64'(valid[0]), 64'd1);
        check("t1_error", 64'(error), 64'd0);

        // 2: glitch after a valid pulse on ch1
        exp_q[1].push_back(150);
        drive_vec(0, 150, 0, 0);
        idle(50);
        drive_vec(0, 10, 0, 0);
        idle(50);
        check("t2_error", 64'(error), 64'b0010);
        check("t2_width1", 64'(pulse_width_1), 64'd150);
        check("t2_valid1", 64'(valid[1]), 64'd1);
        clear_status = 1'b1;
        idle(1);
        clear_status = 1'b0;
        check("t2_error_cleared", 64'(error), 64'd0);

        // 3: over-long pulse on ch2
        servo_in[2] = 1'b1;
        idle(362);
        check("t3_error_before_361", 64'(error[2]), 64'd0);
        idle(1);
        check("t3_error_at_361", 64'(error[2]), 64'd1);
        idle(37);
        servo_in[2] = 1'b0;
        idle(20);
        check("t3_width2_untouched", 64'(pulse_width_2), 64'd0);
        idle(80);
        exp_q[2].push_back(200);
        drive_vec(0, 0, 200, 0);
        idle(20);
        check("t3_error_sticky", 64'(error[2]), 64'd1);
        check("t3_valid2", 64'(valid[2]), 64'd1);

        // 4: loss of signal on ch3
        exp_q[3].push_back(240);
        drive_vec(0, 0, 0, 240);
        idle(4700);
        check("t4_not_lost_yet", 64'(lost[3]), 64'd0);
        idle(200);
        check("t4_lost3", 64'(lost[3]), 64'd1);
        check("t4_valid3", 64'(valid[3]), 64'd0);
        check("t4_width3", 64'(pulse_width_3), 64'd0);
        exp_q[3].push_back(240);
        drive_vec(0, 0, 0, 240);
        idle(10);
        check("t4_lost3_cleared", 64'(lost[3]), 64'd0);
        check("t4_width3_new", 64'(pulse_width_3), 64'd240);

        // 5: reset in the middle of a ch0 pulse
        servo_in[0] = 1'b1;
        idle(100);
        reset_n = 1'b0;
        #1;
        check("t5_reset_widths", {pulse_width_0, pulse_width_1, pulse_width_2, pulse_width_3}, 64'd0);
        check("t5_reset_error", 64'(error), 64'd0);
        check("t5_reset_valid", 64'(valid), 64'd0);
        idle(5);
        reset_n = 1'b1;
        idle(100);
        servo_in[0] = 1'b0;
        idle(50);
        check("t5_partial_ignored", 64'(pulse_width_0), 64'd0);
        check("t5_valid0_still_0", 64'(valid[0]), 64'd0);
        exp_q[0].push_back(120);
        drive_vec(120, 0, 0, 0);
        idle(20);
        check("t5_width0_min", 64'(pulse_width_0), 64'd120);

        // 6: aligned falling edges on all four channels with clear_status colliding
        check("t6_error_pre", 64'(error), 64'd0);
        exp_q[0].push_back(120);
        exp_q[1].push_back(121);
        exp_q[2].push_back(360);
        drive_vec(120, 121, 360, 119);
        idle(2);
        clear_status = 1'b1;
        idle(1);
        clear_status = 1'b0;
        check("t6_new_sample", 64'(new_sample), 64'b0111);
        check("t6_error_set_wins", 64'(error), 64'b1000);
        idle(5);
        check("t6_error_sticky", 64'(error), 64'b1000);
        check("t6_new_sample_done", 64'(new_sample), 64'd0);

        idle(10);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("pending_expect_ch%0d", c), 64'(exp_q[c].size()), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
